// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Included by the sampler and the receiver top through a wildcard import.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: two-flop synchroniser, start-edge detect and a
// three-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OSR = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic [$clog2(OSR)-1:0] os_cnt,
  output logic                   rx_s,
  output logic                   fall,
  output logic                   bit_val,
  output logic                   bit_strobe
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] SAMP_A = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] SAMP_B = CW'(OSR / 2);
  localparam logic [CW-1:0] SAMP_C = CW'(OSR / 2 + 1);

  logic       rx_meta;
  logic       rx_s_d;
  logic       samp_a;
  logic       samp_b;
  logic [1:0] settle;

  // A line already low when reset releases must not look like a start edge,
  // so edges are ignored until the synchroniser has flushed its reset ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      settle  <= 2'd0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (os_cnt == SAMP_A) samp_a <= rx_s;
      if (os_cnt == SAMP_B) samp_b <= rx_s;
    end
  end

  assign fall       = (settle == 2'd3) & rx_s_d & ~rx_s;
  assign bit_strobe = (os_cnt == SAMP_C);
  assign bit_val    = maj3(samp_a, samp_b, rx_s);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM, bit counters, shift register and a
// valid/ready holding register with parity, framing, overrun and break status.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int CW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] OS_LAST   = CW'(OSR - 1);
  localparam logic [BW-1:0] BITS_DONE = BW'(DATA_BITS);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  rx_state_e            state;
  logic [CW-1:0]        os_cnt;
  logic [CW-1:0]        os_next;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 rx_s;
  logic                 fall;
  logic                 bit_val;
  logic                 bit_strobe;
  logic                 stop_last;
  logic                 brk_now;
  logic                 done_now;

  uart_rx_sampler #(.OSR(OSR)) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .os_cnt     (os_cnt),
    .rx_s       (rx_s),
    .fall       (fall),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

  assign os_next   = (os_cnt == OS_LAST) ? '0 : os_cnt + CW'(1);
  assign stop_last = (bit_cnt == STOP_LAST);
  assign brk_now   = (state == STOP) && bit_strobe && (bit_cnt == '0) &&
                     (shift == '0) && !bit_val;
  assign done_now  = (state == STOP) && bit_strobe && stop_last && !brk_now;

  // Frame sequencer; the final stop vote returns to IDLE mid-bit so the next
  // start edge has half a bit of margin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          os_cnt <= '0;
          if (fall) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          os_cnt <= os_next;
          if (bit_strobe && bit_val) begin
            state  <= IDLE;
            os_cnt <= '0;
          end else if (os_cnt == OS_LAST) begin
            state <= DATA;
          end
        end
        DATA: begin
          os_cnt <= os_next;
          if (bit_strobe) begin
            shift   <= {bit_val, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          if (os_cnt == OS_LAST && bit_cnt == BITS_DONE) begin
            state    <= (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
            bit_cnt  <= '0;
            stop_bad <= 1'b0;
          end
        end
        uart_pkg::PARITY: begin
          os_cnt <= os_next;
          if (bit_strobe)
            par_bad <= (PAR_MODE == PAR_ODD) ? ~^{shift, bit_val} : ^{shift, bit_val};
          if (os_cnt == OS_LAST) begin
            state    <= STOP;
            bit_cnt  <= '0;
            stop_bad <= 1'b0;
          end
        end
        STOP: begin
          os_cnt <= os_next;
          if (brk_now) begin
            state  <= BRK_WAIT;
            os_cnt <= '0;
          end else if (bit_strobe && stop_last) begin
            state  <= IDLE;
            os_cnt <= '0;
          end else if (bit_strobe) begin
            stop_bad <= stop_bad | ~bit_val;
            bit_cnt  <= bit_cnt + BW'(1);
          end
        end
        BRK_WAIT: begin
          os_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: a finished frame replaces the word only if the old one
  // is gone or being taken this cycle, otherwise it is dropped as an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= brk_now;
      if (done_now) begin
        if (!rx_valid || rx_ready) begin
          rx_valid   <= 1'b1;
          rx_data    <= shift;
          parity_err <= par_bad;
          frame_err  <= stop_bad | ~bit_val;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8E1 receiver checked every cycle against a frame-level
// model, plus an 8N1 instance pinning the 157-cycle latency.
module tb_uart_rx_os;

  localparam int OSR = 16;
  localparam int DB  = 8;
  localparam int LAT = 5 + (1 + DB + 1) * OSR + OSR / 2;

  typedef struct {
    int         at;
    bit         brk;
    logic [7:0] data;
    bit         pe;
    bit         fe;
  } frame_ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, break_det;
  logic [7:0] a_data;
  logic       a_valid, a_pe, a_fe, a_ovr, a_brk;

  frame_ev_t  ev_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         rand_ready_en = 1'b0;
  bit         m_valid, m_pe, m_fe, m_ovr, m_brk;
  logic [7:0] m_data = 8'h00;
  logic       snap_valid, snap_ovr, snap_brk, snap_pe, snap_fe;
  logic [7:0] snap_data;

  uart_rx_os #(.OSR(OSR), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .break_det(break_det)
  );

  uart_rx_os #(.OSR(OSR), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(1'b1), .parity_err(a_pe), .frame_err(a_fe),
    .overrun(a_ovr), .break_det(a_brk)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s @cyc %0d: actual %h, required %h", name, cyc, act, req);
    end
  endtask

  // Frame-level model: each sent frame becomes one event at its commit cycle.
  always @(posedge clk) begin : model_step
    bit        took;
    frame_ev_t ev;
    cyc++;
    if (!reset) begin
      m_ovr = 1'b0;
      m_brk = 1'b0;
      took  = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
        ev = ev_q.pop_front();
        if (ev.at == cyc) begin
          if (ev.brk) begin
            m_brk = 1'b1;
          end else begin
            took = 1'b1;
            if (!m_valid || rx_ready) begin
              m_valid = 1'b1;
              m_data  = ev.data;
              m_pe    = ev.pe;
              m_fe    = ev.fe;
            end else begin
              m_ovr = 1'b1;
            end
          end
        end
      end
      if (!took && m_valid && rx_ready) m_valid = 1'b0;
    end
  end

  always @(posedge reset) begin
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_pe    = 1'b0;
    m_fe    = 1'b0;
    m_ovr   = 1'b0;
    m_brk   = 1'b0;
    ev_q.delete();
  end

  always @(negedge clk)
    check_output("cycle", {19'd0, rx_valid, rx_data, parity_err, frame_err, overrun, break_det},
                 {19'd0, m_valid, m_data, m_pe, m_fe, m_ovr, m_brk});

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) rx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one 8E1 frame (optionally bad parity, low stop, or a one-cycle spike)
  // and snapshots the DUT outputs on the expected commit cycle.
  task automatic apply_stimulus(input logic [7:0] d, input bit par_ok, input bit stop_bit,
                                input int spike_bit, input int spike_off, input bit ready_pulse);
    logic [10:0] bits;
    int          e;
    bits = {stop_bit, par_ok ? ^d : ~^d, d, 1'b0};
    e = cyc;
    ev_q.push_back('{at: e + LAT, brk: (d == 8'h00) && !stop_bit, data: d,
                     pe: !par_ok, fe: !stop_bit});
    for (int b = 0; b < 11; b++) begin
      for (int k = 0; k < OSR; k++) begin
        rx = (b == spike_bit && k == spike_off) ? ~bits[b] : bits[b];
        @(posedge clk);
        #1;
        if (ready_pulse && cyc - e == LAT - 1) rx_ready = 1'b1;
        if (cyc - e == LAT) begin
          snap_valid = rx_valid;
          snap_data  = rx_data;
          snap_pe    = parity_err;
          snap_fe    = frame_err;
          snap_ovr   = overrun;
          snap_brk   = break_det;
          if (ready_pulse) rx_ready = 1'b0;
        end
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    int         e;
    logic [9:0] a_bits;
    logic [7:0] d;
    int         sb;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", {rx_valid, rx_data, parity_err, frame_err, overrun, break_det}, 0);
    check_output("reset_state_a", {a_valid, a_data, a_pe, a_fe, a_ovr, a_brk}, 0);
    reset = 1'b0;
    idle(10);

    // 8N1 latency pin: rx_valid exactly one cycle, 157 cycles after the edge.
    a_bits = {1'b1, 8'hA5, 1'b0};
    e = cyc;
    for (int i = 0; i < 10 * OSR + 4; i++) begin
      rx_a = (i < 10 * OSR) ? a_bits[i / OSR] : 1'b1;
      @(posedge clk);
      #1;
      if (cyc - e == 156) check_output("a5_not_yet", a_valid, 0);
      if (cyc - e == 157) begin
        check_output("a5_valid", a_valid, 1);
        check_output("a5_data", a_data, 8'hA5);
        check_output("a5_flags", {a_pe, a_fe, a_ovr, a_brk}, 0);
      end
      if (cyc - e == 158) check_output("a5_one_cycle", a_valid, 0);
    end

    // Half-bit glitch on the idle line; rx_ready low so a false word would stick.
    rx = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    idle(200);
    check_output("glitch_no_word", {rx_valid, parity_err, frame_err, break_det}, 0);

    rx_ready = 1'b1;
    apply_stimulus(8'h03, 1'b0, 1'b1, -1, 0, 1'b0);
    check_output("par_bad_word", {snap_valid, snap_data, snap_pe, snap_fe}, {1'b1, 8'h03, 1'b1, 1'b0});
    idle(5);
    apply_stimulus(8'h03, 1'b1, 1'b1, -1, 0, 1'b0);
    check_output("par_ok_word", {snap_valid, snap_data, snap_pe}, {1'b1, 8'h03, 1'b0});
    idle(5);
    apply_stimulus(8'h96, 1'b1, 1'b1, 3, 9, 1'b0);
    check_output("spike_masked", {snap_valid, snap_data}, {1'b1, 8'h96});
    idle(5);
    apply_stimulus(8'h5A, 1'b1, 1'b0, -1, 0, 1'b0);
    check_output("frame_err_word", {snap_valid, snap_data, snap_fe}, {1'b1, 8'h5A, 1'b1});
    idle(5);

    rx_ready = 1'b0;
    apply_stimulus(8'h11, 1'b1, 1'b1, -1, 0, 1'b0);
    check_output("hold_first", {snap_valid, snap_data, snap_ovr}, {1'b1, 8'h11, 1'b0});
    idle(3);
    apply_stimulus(8'h22, 1'b1, 1'b1, -1, 0, 1'b0);
    check_output("overrun_drop", {snap_valid, snap_data, snap_ovr}, {1'b1, 8'h11, 1'b1});
    idle(3);
    apply_stimulus(8'h22, 1'b1, 1'b1, -1, 0, 1'b1);
    check_output("accept_and_load", {snap_valid, snap_data, snap_ovr}, {1'b1, 8'h22, 1'b0});
    rx_ready = 1'b1;
    idle(5);

    // Line held low for 20 bit-times.
    e = cyc;
    ev_q.push_back('{at: e + LAT, brk: 1'b1, data: 8'h00, pe: 1'b0, fe: 1'b1});
    rx = 1'b0;
    for (int i = 0; i < 20 * OSR; i++) begin
      @(posedge clk);
      #1;
      if (cyc - e == LAT) check_output("break_pulse", {break_det, rx_valid}, 2'b10);
      if (cyc - e == LAT + 1) check_output("break_single", {break_det, rx_valid}, 2'b00);
    end
    idle(20);
    rx_ready = 1'b0;
    apply_stimulus(8'h7E, 1'b1, 1'b1, -1, 0, 1'b0);
    check_output("after_break", {snap_valid, snap_data}, {1'b1, 8'h7E});

    // Reset mid-frame with the line low at release.
    rx = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    rx = 1'b1;
    repeat (16) begin @(posedge clk); #1; end
    rx = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check_output("reset_clears", {rx_valid, rx_data}, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    idle(20);
    rx_ready = 1'b1;
    apply_stimulus(8'h3C, 1'b1, 1'b1, -1, 0, 1'b0);
    check_output("after_reset", {snap_valid, snap_data, snap_pe, snap_fe}, {1'b1, 8'h3C, 2'b00});
    idle(5);

    // Randomised traffic with random back-pressure, errors and spikes.
    rand_ready_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      apply_stimulus(d, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                     sb, int'($urandom_range(8, 10)), 1'b0);
      idle(int'($urandom_range(2, 30)));
    end
    rand_ready_en = 1'b0;
    #2;
    rx_ready = 1'b1;
    idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
